// File: rtl/rc5_s_table_ctrl.sv
// RC5 S-table controller: fills S[0..T-1] with P + k*Q through RAM port A,
// then serves handshaked single-word reads through RAM port B.
module rc5_s_table_ctrl #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            ADDR_WIDTH = 6,
  parameter int unsigned            T          = 26,
  parameter logic [DATA_WIDTH-1:0]  P_CONST    = DATA_WIDTH'(32'hB7E15163),
  parameter logic [DATA_WIDTH-1:0]  Q_CONST    = DATA_WIDTH'(32'h9E3779B9)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  table_valid,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_data_a,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic [DATA_WIDTH-1:0] ram_data_b,
  output logic                  ram_we_b,
  input  logic [DATA_WIDTH-1:0] ram_q_b,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ready,
  output logic                  rd_data_valid,
  output logic [DATA_WIDTH-1:0] rd_data
);

  // One extra index bit so T == 2**ADDR_WIDTH cannot wrap before the last write
  localparam int unsigned  CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] K_END = CW'(T);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           k_q, k_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic                    busy_d, done_d, tv_d, we_a_d;
  logic [ADDR_WIDTH-1:0]   addr_a_d;
  logic [DATA_WIDTH-1:0]   data_a_d;
  logic [ADDR_WIDTH-1:0]   addr_b_q;
  logic                    rd_pend_q;
  logic                    rd_accept;

  // Port B is read-only
  assign ram_data_b = '0;
  assign ram_we_b   = 1'b0;

  // Reads are only served from a complete table while no fill is running
  assign rd_ready   = table_valid && (state_q == S_IDLE);
  assign rd_accept  = rd_req && rd_ready;

  // Address reaches the RAM in the acceptance cycle; otherwise hold the last one
  assign ram_addr_b = rd_accept ? rd_addr : addr_b_q;

  // Next-state and registered-output logic for the fill sequencer
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    acc_d    = acc_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    tv_d     = table_valid;
    we_a_d   = 1'b0;
    addr_a_d = ram_addr_a;
    data_a_d = ram_data_a;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // First write (k=0) goes out on the same edge that samples start
          we_a_d   = 1'b1;
          busy_d   = 1'b1;
          addr_a_d = k_q[ADDR_WIDTH-1:0];
          data_a_d = acc_q;
          k_d      = k_q + CW'(1);
          acc_d    = acc_q + Q_CONST;
          tv_d     = 1'b0;
          state_d  = S_FILL;
        end
      end
      S_FILL: begin
        if (k_q == K_END) begin
          done_d  = 1'b1;
          tv_d    = 1'b1;
          k_d     = '0;
          acc_d   = P_CONST;
          state_d = S_DONE;
        end else begin
          we_a_d   = 1'b1;
          busy_d   = 1'b1;
          addr_a_d = k_q[ADDR_WIDTH-1:0];
          data_a_d = acc_q;
          k_d      = k_q + CW'(1);
          acc_d    = acc_q + Q_CONST;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and fill-side output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      acc_q       <= P_CONST;
      busy        <= 1'b0;
      done        <= 1'b0;
      table_valid <= 1'b0;
      ram_we_a    <= 1'b0;
      ram_addr_a  <= '0;
      ram_data_a  <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      busy        <= busy_d;
      done        <= done_d;
      table_valid <= tv_d;
      ram_we_a    <= we_a_d;
      ram_addr_a  <= addr_a_d;
      ram_data_a  <= data_a_d;
    end
  end

  // Read pipeline: RAM latency stage, then capture of ram_q_b
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_b_q      <= '0;
      rd_pend_q     <= 1'b0;
      rd_data_valid <= 1'b0;
      rd_data       <= '0;
    end else begin
      addr_b_q      <= ram_addr_b;
      rd_pend_q     <= rd_accept;
      rd_data_valid <= rd_pend_q;
      if (rd_pend_q) begin
        rd_data <= ram_q_b;
      end
    end
  end

endmodule

// File: doc/rc5_s_table_ctrl.md
Name: rc5_s_table_ctrl

Overview:
- Initiator-side controller for the RC5 S-table dual-port RAM (8..64-bit words, 1-cycle registered read, write-first on write).
- On `start`, fills `S[0..T-1]` through RAM port A with the RC5 magic-constant sequence `S[0]=P`, `S[i]=S[i-1]+Q mod 2^w`.
- Afterwards serves handshaked single-word reads from the key-schedule/cipher datapath through RAM port B, accounting for the RAM read latency.

Parameters:
- DATA_WIDTH, 32, word size w (RAM data width).
- ADDR_WIDTH, 6, RAM address width.
- T, 26, table length 2r+2 (r=12); must satisfy 1 <= T <= 2**ADDR_WIDTH.
- P_CONST, 32'hB7E15163, RC5 magic constant Pw.
- Q_CONST, 32'h9E3779B9, RC5 magic constant Qw.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a table fill; single-cycle pulse or level.
- busy  out  1  high while the fill is in progress.
- done  out  1  one-cycle pulse after the last fill write.
- table_valid  out  1  table completely filled since the last reset.
- ram_addr_a  out  ADDR_WIDTH  RAM port A address.
- ram_data_a  out  DATA_WIDTH  RAM port A write data.
- ram_we_a  out  1  RAM port A write enable.
- ram_addr_b  out  ADDR_WIDTH  RAM port B address.
- ram_data_b  out  DATA_WIDTH  RAM port B write data, tied 0.
- ram_we_b  out  1  RAM port B write enable, tied 0.
- ram_q_b  in  DATA_WIDTH  RAM port B read data, valid 1 cycle after address.
- rd_req  in  1  read request from the consumer.
- rd_addr  in  ADDR_WIDTH  read index.
- rd_ready  out  1  read request is accepted this cycle.
- rd_data_valid  out  1  rd_data is valid.
- rd_data  out  DATA_WIDTH  returned word.

Behaviour:
- All outputs are registered except `rd_ready` (combinational from state and table_valid) and the `ram_*_b` tie-offs.
- Reset values: busy=0, done=0, table_valid=0, ram_we_a=0, ram_addr_a=0, ram_data_a=0, ram_addr_b=0, rd_data_valid=0, rd_data=0; state=IDLE, index k=0, accumulator=P_CONST.

FSM:
- IDLE: if start=1, go to FILL next cycle.
- FILL: one write per cycle for k=0..T-1, with ram_we_a=1, ram_addr_a=k, ram_data_a=P+k*Q (mod 2^w).
  - Implement the data with a running adder, not a multiplier.
  - busy=1 in each FILL cycle.
  - After the k=T-1 write cycle, go to DONE.
- DONE: one cycle with done=1, busy=0, ram_we_a=0; table_valid is set to 1 and remains set. Then return to IDLE.
- Latency: start sampled high at edge N gives the first write visible in cycle N+1 and the last write in cycle N+T. done=1 in cycle N+T+1.

Fill boundaries:
- start is ignored while in FILL or DONE. No restart and no queueing.
- start while in IDLE with table_valid=1 refills. table_valid drops to 0 on the cycle FILL is entered and stays 0 until DONE.
- T=2**ADDR_WIDTH: the index must not wrap before the final write. The counter is ADDR_WIDTH+1 bits wide, or the compare is done before the increment.
- Adder overflow wraps modulo 2^DATA_WIDTH with no flag.
- rst during FILL: immediate return to IDLE with all outputs at reset values. RAM contents are partial and table_valid=0.

Read port:
- rd_ready = table_valid AND state==IDLE.
- Accept a read when rd_req AND rd_ready. In the acceptance cycle ram_addr_b is driven with rd_addr; this path is combinational so the RAM captures the address at the same edge.
- One cycle later, rd_data=ram_q_b registered and rd_data_valid=1. Total request-to-data latency is 2 edges.
- Back-to-back requests give one result per cycle, in order.
- A read accepted in the last IDLE cycle before a start still returns its data. Pipeline registers are not flushed by start, only by rst.
- rd_addr >= T returns the RAM content at that address. This is not an error.

Test Plan:
- rst, then start pulse at edge N -> ram_we_a=1 for cycles N+1..N+26; written data S[0]=0xB7E15163, S[1]=0x5618CB1C, S[2]=0xF45044D5, S[25]=0x2B4C3474; done=1 only at N+27, then table_valid=1.
- After fill, rd_req with rd_addr=1,2,25 on consecutive cycles -> rd_data_valid on the three following cycles with 0x5618CB1C, 0xF45044D5, 0x2B4C3474, in order.
- rd_req before any fill, or during FILL -> rd_ready=0, no rd_data_valid, ram_we_b always 0.
- start re-asserted at fill cycle 5, and held high throughout -> exactly one fill of 26 writes; a second fill starts only after returning to IDLE.
- rst asserted at fill cycle 10 -> next cycle busy=0, ram_we_a=0, table_valid=0, done never pulses; a fresh start then completes a full 26-write fill.
- Parameter T=64, ADDR_WIDTH=6 -> 64 writes at addresses 0..63, no write to address 0 after address 63, done one cycle after the write to 63.
